// File: rtl/bram_tdp_param_ram_pkg.sv
// Shared types for the true-dual-port RAM: write modes, init FSM states
// and a lane-count helper used by the interface and the RAM itself.
package bram_pkg;

    typedef enum logic [1:0] {
        READ_FIRST  = 2'd0,
        WRITE_FIRST = 2'd1,
        NO_CHANGE   = 2'd2
    } wr_mode_e;

    typedef enum logic {
        S_INIT  = 1'b0,
        S_READY = 1'b1
    } init_state_e;

    function automatic int nbytes(input int dw, input int bw);
        return dw / bw;
    endfunction

endpackage

// File: rtl/bram_tdp_param_ram_if.sv
// One RAM access port: en/we/addr/din in, dout/dout_valid out.
// master = requester side, slave = RAM side.
interface bram_tdp_param_ram_if
    import bram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int DEPTH      = 1024
);
    localparam int NBYTES = nbytes(DATA_WIDTH, BYTE_WIDTH);
    localparam int ADDR_W = $clog2(DEPTH);

    logic                  en;
    logic [NBYTES-1:0]     we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;

    modport master (
        output en, we, addr, din,
        input  dout, dout_valid
    );

    modport slave (
        input  en, we, addr, din,
        output dout, dout_valid
    );

endinterface

// File: rtl/bram_tdp_param_ram_out_pipe.sv
// Per-port read pipeline of depth 1+OUT_REG with NO_CHANGE suppression.
// Ports: clk, rst_n, i_acc, i_wr, i_data in; o_data, o_valid out.
module bram_out_pipe
    import bram_pkg::*;
#(
    parameter int       DATA_WIDTH = 32,
    parameter int       OUT_REG    = 1,
    parameter wr_mode_e WRITE_MODE = READ_FIRST
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_acc,
    input  logic                  i_wr,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid
);

    logic                  w_take;
    logic                  r_v1;
    logic [DATA_WIDTH-1:0] r_d1;

    // Writes in NO_CHANGE mode never reach the output.
    assign w_take = i_acc &&
        !(WRITE_MODE == NO_CHANGE && i_wr);

    // Data only moves with a valid, so dout holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_d1 <= '0;
        end else begin
            r_v1 <= w_take;
            if (w_take) r_d1 <= i_data;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic                  r_v2;
            logic [DATA_WIDTH-1:0] r_d2;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_v2 <= 1'b0;
                    r_d2 <= '0;
                end else begin
                    r_v2 <= r_v1;
                    if (r_v1) r_d2 <= r_d1;
                end
            end

            assign o_data  = r_d2;
            assign o_valid = r_v2;
        end else begin : g_noreg
            assign o_data  = r_d1;
            assign o_valid = r_v1;
        end
    endgenerate

endmodule

// File: rtl/bram_tdp_param_ram.sv
// True-dual-port byte-write RAM with init sequencer and read pipelines.
// Ports: clk, rst_n, init_done, collision, a/b access ports (slave).
// Optional macro BRAM_COLLISION_DETECT_EN enables the collision pulse.
module bram_tdp_param_ram
    import bram_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    BYTE_WIDTH = 8,
    parameter int                    DEPTH      = 1024,
    parameter wr_mode_e              WRITE_MODE = READ_FIRST,
    parameter int                    OUT_REG    = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic clk,
    input  logic rst_n,
    output logic init_done,
    output logic collision,
    bram_tdp_param_ram_if.slave a,
    bram_tdp_param_ram_if.slave b
);

    localparam int NBYTES = nbytes(DATA_WIDTH, BYTE_WIDTH);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int BW     = BYTE_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    init_state_e       r_state;
    init_state_e       w_state_nx;
    logic [ADDR_W-1:0] r_init_addr;
    logic [ADDR_W-1:0] w_init_addr_nx;

    logic w_ready;
    logic w_a_acc;
    logic w_b_acc;
    logic w_a_wr;
    logic w_b_wr;
    logic w_same;

    logic [DATA_WIDTH-1:0] w_a_old;
    logic [DATA_WIDTH-1:0] w_b_old;
    logic [DATA_WIDTH-1:0] w_a_fin;
    logic [DATA_WIDTH-1:0] w_b_fin;
    logic [DATA_WIDTH-1:0] w_a_rd;
    logic [DATA_WIDTH-1:0] w_b_rd;
    logic [DATA_WIDTH-1:0] w_a_dout;
    logic [DATA_WIDTH-1:0] w_b_dout;
    logic                  w_a_vld;
    logic                  w_b_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_INIT;
            r_init_addr <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_init_addr <= w_init_addr_nx;
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_init_addr_nx = r_init_addr;
        unique case (r_state)
            S_INIT: begin
                w_init_addr_nx = r_init_addr + 1'b1;
                if (r_init_addr == ADDR_W'(DEPTH - 1)) begin
                    w_state_nx     = S_READY;
                    w_init_addr_nx = '0;
                end
            end
            S_READY: begin
                w_state_nx = S_READY;
            end
        endcase
    end

    assign w_ready   = (r_state == S_READY);
    assign init_done = w_ready;

    // User ports are locked out until the sweep finishes.
    assign w_a_acc = a.en && w_ready;
    assign w_b_acc = b.en && w_ready;
    assign w_a_wr  = w_a_acc && (|a.we);
    assign w_b_wr  = w_b_acc && (|b.we);
    assign w_same  = (a.addr == b.addr);

    assign w_a_old = r_mem[a.addr];
    assign w_b_old = r_mem[b.addr];

    // Word as it will stand after this cycle at each port's
    // address; A owns any lane both ports write.
    always_comb begin
        w_a_fin = w_a_old;
        w_b_fin = w_b_old;
        for (int i = 0; i < NBYTES; i++) begin
            if (w_a_acc && a.we[i])
                w_a_fin[i*BW +: BW] = a.din[i*BW +: BW];
            else if (w_b_acc && b.we[i] && w_same)
                w_a_fin[i*BW +: BW] = b.din[i*BW +: BW];

            if (w_a_acc && a.we[i] && w_same)
                w_b_fin[i*BW +: BW] = a.din[i*BW +: BW];
            else if (w_b_acc && b.we[i])
                w_b_fin[i*BW +: BW] = b.din[i*BW +: BW];
        end
    end

    // A plain read always sees the pre-cycle word, even when the
    // other port writes the same address.
    assign w_a_rd = (WRITE_MODE == WRITE_FIRST && w_a_wr) ?
                    w_a_fin : w_a_old;
    assign w_b_rd = (WRITE_MODE == WRITE_FIRST && w_b_wr) ?
                    w_b_fin : w_b_old;

    // B lanes land first so A overwrites them on a shared lane.
    always_ff @(posedge clk) begin
        if (!w_ready) begin
            r_mem[r_init_addr] <= INIT_VALUE;
        end else begin
            for (int i = 0; i < NBYTES; i++) begin
                if (w_b_acc && b.we[i])
                    r_mem[b.addr][i*BW +: BW] <= b.din[i*BW +: BW];
            end
            for (int i = 0; i < NBYTES; i++) begin
                if (w_a_acc && a.we[i])
                    r_mem[a.addr][i*BW +: BW] <= a.din[i*BW +: BW];
            end
        end
    end

    bram_out_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_REG    (OUT_REG),
        .WRITE_MODE (WRITE_MODE)
    ) u_pipe_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_acc   (w_a_acc),
        .i_wr    (w_a_wr),
        .i_data  (w_a_rd),
        .o_data  (w_a_dout),
        .o_valid (w_a_vld)
    );

    bram_out_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_REG    (OUT_REG),
        .WRITE_MODE (WRITE_MODE)
    ) u_pipe_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_acc   (w_b_acc),
        .i_wr    (w_b_wr),
        .i_data  (w_b_rd),
        .o_data  (w_b_dout),
        .o_valid (w_b_vld)
    );

    assign a.dout       = w_a_dout;
    assign a.dout_valid = w_a_vld;
    assign b.dout       = w_b_dout;
    assign b.dout_valid = w_b_vld;

`ifdef BRAM_COLLISION_DETECT_EN
    logic r_coll;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_coll <= 1'b0;
        end else begin
            r_coll <= w_a_acc && w_b_acc && w_same &&
                      (w_a_wr || w_b_wr);
        end
    end

    assign collision = r_coll;
`else
    assign collision = 1'b0;
`endif

endmodule

// File: doc/bram_tdp_param_ram.md
BRAM_TDP_PARAM_RAM -- requirements
Module: bram_tdp_param_ram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits; a multiple of BYTE_WIDTH.
REQ-002 SHALL have parameter BYTE_WIDTH, default 8, write-enable lane width; NBYTES = DATA_WIDTH/BYTE_WIDTH.
REQ-003 SHALL have parameter DEPTH, default 1024, number of words; ADDR_W = $clog2(DEPTH).
REQ-004 SHALL have parameter WRITE_MODE, default READ_FIRST, of type bram_pkg::wr_mode_e, one of READ_FIRST, WRITE_FIRST, NO_CHANGE, applied to both ports.
REQ-005 SHALL have parameter OUT_REG, default 1, extra output register stage (0 or 1).
REQ-006 SHALL have parameter INIT_VALUE, default 0, word written to every address by the init sequencer.
REQ-007 SHALL have ports: clk in 1 the single clock; rst_n in 1 asynchronous active-low reset.
REQ-008 SHALL have ports: init_done out 1, high once memory initialisation has completed.
REQ-009 SHALL have, for each port p in {a,b}: p_en in 1 access enable; p_we in NBYTES per-lane write enable; p_addr in ADDR_W; p_din in DATA_WIDTH; p_dout out DATA_WIDTH; p_dout_valid out 1.
REQ-010 SHALL have port collision out 1, one-cycle pulse marking a same-address conflict.

Function
REQ-011 SHALL run an init FSM with states INIT and READY; INIT writes INIT_VALUE to addresses 0..DEPTH-1, one per cycle via port A, then goes to READY and sets init_done.
REQ-012 SHALL ignore p_en on both ports while in INIT: no writes, no reads, no valid pulses.
REQ-013 SHALL write lane i of p_din to the addressed word when p_en and p_we[i] are both high; lanes with p_we[i]=0 are unchanged.
REQ-014 SHALL perform a read on every enabled access; p_dout_valid rises exactly 1+OUT_REG cycles after the access, for one cycle per access.
REQ-015 SHALL return, for an access with any p_we bit set: in READ_FIRST, the old word; in WRITE_FIRST, the merged new word; in NO_CHANGE, no update to p_dout and no p_dout_valid pulse.
REQ-016 SHALL hold p_dout at its last value when no valid data is presented.
REQ-017 SHALL resolve a same-address write/write conflict per lane: A wins lanes both ports write; lanes written only by B take B's data.
REQ-018 SHALL give a port that reads an address the other port writes in the same cycle the pre-cycle word, in every WRITE_MODE.
REQ-019 SHALL sustain full throughput: one access per port per cycle, with back-to-back accesses fully pipelined.

Reset
REQ-020 SHALL on rst_n low asynchronously clear p_dout, p_dout_valid, collision, init_done and the pipeline valids, and enter INIT at address 0.
REQ-021 SHALL, on reset asserted mid-operation or mid-INIT, drop in-flight reads without a valid pulse and restart initialisation from address 0.

Configuration
REQ-022 SHALL pulse collision, with the macro BRAM_COLLISION_DETECT_EN defined, one cycle after any cycle in which both ports are enabled, the addresses match, and at least one port writes.
REQ-023 SHALL, without BRAM_COLLISION_DETECT_EN, tie collision to 0 and omit its logic; the write resolution of REQ-017/018 is unchanged.

Structure
REQ-024 SHALL take wr_mode_e and any shared width helpers from package bram_pkg.
REQ-025 SHALL instantiate sub-module bram_out_pipe once per port, holding the read-data/valid pipeline of depth 1+OUT_REG and the NO_CHANGE suppression.

Verification
REQ-026 SHALL cover: reset, then DEPTH=16 -> init_done high exactly 16 cycles after rst_n rises; every read returns INIT_VALUE.
REQ-027 SHALL cover: READ_FIRST, OUT_REG=1; write 0xDEADBEEF to addr 5, then write 0x11111111 to addr 5 -> second access returns 0xDEADBEEF with valid 2 cycles later.
REQ-028 SHALL cover: a_we=4'b0011 with din 0xAAAAAAAA on word 0x12345678 -> later read returns 0x1234AAAA.
REQ-029 SHALL cover: same-cycle writes to addr 3, A we=4'b0011 din 0x000000AA, B we=4'b1111 din 0xBBBBBBBB -> word becomes 0xBBBB00AA; collision pulses once when the macro is defined.
REQ-030 SHALL cover: rst_n pulsed low while three reads are in flight -> no p_dout_valid pulses afterwards, init restarts, and init_done goes low then high after DEPTH cycles.
